// File: rtl/spi_master_aes_if.sv
// Host-side request/response bundle for spi_master_aes: plaintext and key in,
// ciphertext and transaction status out.
interface spi_master_aes_if #(
    parameter int Nk = 4
);
    logic              start;
    logic [127:0]      data_in;
    logic [32*Nk-1:0]  key_in;
    logic [127:0]      data_out;
    logic              busy;
    logic              done;

    modport master (
        output start, data_in, key_in,
        input  data_out, busy, done
    );

    modport slave (
        input  start, data_in, key_in,
        output data_out, busy, done
    );
endinterface

// File: rtl/spi_master_aes.sv
// SPI master for an AES slave: shifts plaintext+key out, clocks 128 dummy periods
// to read the ciphertext back, and presents it on data_out with a done pulse.
module spi_master_aes #(
    parameter int Nk      = 4,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_aes_if.slave  io_host,
    output logic             o_sclk,
    output logic             o_mosi,
    input  logic             i_miso,
    output logic             o_cs
);
    localparam int TX_W  = 128 + 32*Nk;
    localparam int N_PER = 256 + 32*Nk;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] SHIFT_HI = 3'd2;
    localparam logic [2:0] SHIFT_LO = 3'd3;
    localparam logic [2:0] FINISH   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [9:0] LAST_PER = 10'(N_PER - 1);
    localparam logic [9:0] FIRST_RX = 10'(TX_W);

    logic [2:0]      r_state;
    logic [7:0]      r_div;
    logic [9:0]      r_per;
    logic [TX_W-1:0] r_tx;
    logic [127:0]    r_rx;
    logic [127:0]    r_dout;
    logic            r_sclk;
    logic            r_mosi;
    logic            r_cs;
    logic            r_busy;
    logic            r_done;

    logic            w_div_end;
    logic            w_rx_per;

    assign w_div_end = (r_div == 8'd0);
    assign w_rx_per  = (r_per >= FIRST_RX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_per   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_host.start) begin
                        // Bit 127 goes straight to MOSI; the register keeps the rest, zero-filled behind.
                        r_tx    <= {io_host.data_in[126:0], io_host.key_in, 1'b0};
                        r_mosi  <= io_host.data_in[127];
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_sclk  <= 1'b0;
                        r_div   <= DIV_LAST;
                        r_per   <= '0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_div_end) begin
                        r_sclk  <= 1'b1;
                        r_div   <= DIV_LAST;
                        r_state <= SHIFT_HI;
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (w_div_end) begin
                        if (w_rx_per) begin
                            r_rx <= {r_rx[126:0], i_miso};
                        end
                        r_mosi  <= r_tx[TX_W-1];
                        r_tx    <= {r_tx[TX_W-2:0], 1'b0};
                        r_sclk  <= 1'b0;
                        r_div   <= DIV_LAST;
                        r_state <= SHIFT_LO;
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (w_div_end) begin
                        if (r_per == LAST_PER) begin
                            r_cs    <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_dout  <= r_rx;
                            r_state <= FINISH;
                        end else begin
                            r_per   <= r_per + 10'd1;
                            r_sclk  <= 1'b1;
                            r_div   <= DIV_LAST;
                            r_state <= SHIFT_HI;
                        end
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_sclk           = r_sclk;
    assign o_mosi           = r_mosi;
    assign o_cs             = r_cs;
    assign io_host.data_out = r_dout;
    assign io_host.busy     = r_busy;
    assign io_host.done     = r_done;
endmodule

// File: tb/tb_spi_master_aes.sv
// Bench for spi_master_aes: two instances (Nk=4/CLK_DIV=2 and Nk=8/CLK_DIV=1),
// a behavioural AES-slave stand-in on the SPI pins, and a timeline model of the outputs.
module tb_spi_master_aes;
    localparam int NK0 = 4;
    localparam int DIV0 = 2;
    localparam int NK1 = 8;
    localparam int DIV1 = 1;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_aes_if #(.Nk(NK0)) bus0 ();
    spi_master_aes_if #(.Nk(NK1)) bus1 ();

    logic sclk0, mosi0, cs0, sclk1, mosi1, cs1;
    logic [1:0] miso = 2'b00;
    logic [1:0] sclk_v, mosi_v, cs_v;
    assign sclk_v = {sclk1, sclk0};
    assign mosi_v = {mosi1, mosi0};
    assign cs_v   = {cs1, cs0};

    spi_master_aes #(.Nk(NK0), .CLK_DIV(DIV0)) u_dut0 (
        .clk(clk), .rst(rst), .io_host(bus0.slave),
        .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(miso[0]), .o_cs(cs0)
    );

    spi_master_aes #(.Nk(NK1), .CLK_DIV(DIV1)) u_dut1 (
        .clk(clk), .rst(rst), .io_host(bus1.slave),
        .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(miso[1]), .o_cs(cs1)
    );

    int checks = 0;
    int failures = 0;

    function automatic int nk_of(int g);     return (g == 0) ? NK0 : NK1;              endfunction
    function automatic int div_of(int g);    return (g == 0) ? DIV0 : DIV1;            endfunction
    function automatic int txw_of(int g);    return 128 + 32 * nk_of(g);               endfunction
    function automatic int nper_of(int g);   return 256 + 32 * nk_of(g);               endfunction
    function automatic int busy_len(int g);  return div_of(g) * (1 + 2 * nper_of(g));  endfunction

    // Slave's answer to a received stream (left-aligned in 512 bits): the FIPS-197
    // vectors are recognised, anything else gets a deterministic stand-in cipher.
    function automatic logic [127:0] oracle(logic [511:0] s, int txw);
        if (txw == 256 && s[511:256] == {PT, K128}) return CT128;
        if (txw == 384 && s[511:128] == {PT, K256}) return CT256;
        return s[511:384] ^ {s[382:256], s[383]} ^ s[255:128] ^ 128'h5a5a_c3c3_0ff0_1234_8765_a5a5_3c3c_f00f;
    endfunction

    // Key is passed left-aligned in 256 bits; Nk=4 uses the upper half.
    function automatic logic [511:0] stream_of(int g, logic [127:0] pt, logic [255:0] k);
        return (g == 0) ? {pt, k[255:128], 256'b0} : {pt, k, 128'b0};
    endfunction

    function automatic logic done_of(int g);
        return (g == 0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic [132:0] act_vec(int g);
        if (g == 0) return {bus0.data_out, cs0, sclk0, mosi0, bus0.busy, bus0.done};
        return {bus1.data_out, cs1, sclk1, mosi1, bus1.busy, bus1.done};
    endfunction

    // Timeline model: t_m counts edges since the accepting edge, -1 when idle.
    int cyc = 0;
    int t_m [2] = '{-1, -1};
    logic [511:0] tx_m   [2] = '{default: '0};
    logic [127:0] ct_m   [2] = '{default: '0};
    logic [127:0] dout_m [2] = '{default: '0};

    function automatic logic host_start(int g);
        return (g == 0) ? bus0.start : bus1.start;
    endfunction

    function automatic logic [511:0] host_stream(int g);
        if (g == 0) return {bus0.data_in, bus0.key_in, 256'b0};
        return {bus1.data_in, bus1.key_in, 128'b0};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                t_m[g]    <= -1;
                dout_m[g] <= '0;
            end else if (t_m[g] < 0) begin
                if (host_start(g)) begin
                    t_m[g]  <= 0;
                    tx_m[g] <= host_stream(g);
                    ct_m[g] <= oracle(host_stream(g), txw_of(g));
                end
            end else if (t_m[g] < busy_len(g)) begin
                t_m[g] <= t_m[g] + 1;
                if (t_m[g] + 1 == busy_len(g)) dout_m[g] <= ct_m[g];
            end else begin
                t_m[g] <= -1;
            end
        end
    end

    // Expected {data_out, cs, sclk, mosi, busy, done} from the position in the timeline.
    function automatic logic [132:0] exp_vec(int g);
        int t = t_m[g];
        int d = div_of(g);
        int bl = busy_len(g);
        int ph, p, b;
        logic sck, mo;
        if (t >= 0 && t < bl) begin
            ph = t / d;
            if (ph == 0) begin
                sck = 1'b0;
                b = 0;
            end else begin
                p = (ph - 1) / 2;
                sck = ((ph - 1) % 2) == 0;
                b = sck ? p : p + 1;
            end
            mo = (b < txw_of(g)) ? tx_m[g][511 - b] : 1'b0;
            return {dout_m[g], 1'b0, sck, mo, 1'b1, 1'b0};
        end
        if (t == bl) return {dout_m[g], 1'b1, 3'b000, 1'b1};
        return {dout_m[g], 1'b1, 4'b0000};
    endfunction

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int g = 0; g < 2; g++)
                    chk($sformatf("cyc%0d_dut%0d_outputs", cyc, g), 512'(act_vec(g)), 512'(exp_vec(g)));
            end
        end
    endtask

    // AES-slave stand-in: captures MOSI on SCLK rise, drives MISO on SCLK fall.
    int s_rises [2] = '{0, 0};
    logic [511:0] s_rx [2] = '{default: '0};
    logic [127:0] s_ct [2] = '{default: '0};
    int last_rises [2] = '{0, 0};
    logic [511:0] last_stream [2] = '{default: '0};

    task automatic slave_loop();
        logic [1:0] sclk_q = 2'b00;
        logic [1:0] cs_q = 2'b11;
        int txw;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                txw = txw_of(g);
                if (cs_v[g] === 1'b1) begin
                    if (cs_q[g] === 1'b0) begin
                        last_rises[g] = s_rises[g];
                        last_stream[g] = s_rx[g] << (512 - s_rises[g]);
                    end
                    s_rises[g] = 0;
                    s_rx[g] = '0;
                    miso[g] = 1'b0;
                end else if (sclk_v[g] && !sclk_q[g]) begin
                    s_rises[g]++;
                    s_rx[g] = {s_rx[g][510:0], mosi_v[g]};
                end else if (!sclk_v[g] && sclk_q[g]) begin
                    if (s_rises[g] == txw) s_ct[g] = oracle(s_rx[g] << (512 - txw), txw);
                    if (s_rises[g] >= txw && s_rises[g] < txw + 128) begin
                        miso[g] = s_ct[g][127];
                        s_ct[g] = s_ct[g] << 1;
                    end else begin
                        miso[g] = 1'b0;
                    end
                end
            end
            sclk_q = sclk_v;
            cs_q = cs_v;
        end
    endtask

    task automatic drive(int g, logic st, logic [127:0] pt, logic [255:0] k);
        if (g == 0) begin
            bus0.start = st; bus0.data_in = pt; bus0.key_in = k[255:128];
        end else begin
            bus1.start = st; bus1.data_in = pt; bus1.key_in = k;
        end
    endtask

    task automatic set_start(int g, logic st);
        if (g == 0) bus0.start = st;
        else bus1.start = st;
    endtask

    // Returns on the negedge right after the edge that samples start.
    task automatic pulse_start(int g, logic [127:0] pt, logic [255:0] k);
        @(negedge clk);
        drive(g, 1'b1, pt, k);
        @(negedge clk);
        set_start(g, 1'b0);
    endtask

    task automatic wait_done(int g, int limit, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done_of(g) !== 1'b1 && lat < limit);
    endtask

    task automatic run_txn(int g, logic [127:0] pt, logic [255:0] k, output int lat);
        pulse_start(g, pt, k);
        wait_done(g, busy_len(g) + 20, lat);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int lat;
        logic [127:0] pt;
        logic [255:0] k;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        fork
            compare_loop();
            slave_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_dut0", 512'(act_vec(0)), 512'({128'b0, 5'b10000}));
        chk("reset_dut1", 512'(act_vec(1)), 512'({128'b0, 5'b10000}));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // FIPS-197 AES-128 through the Nk=4 instance
        run_txn(0, PT, {K128, 128'b0}, lat);
        chk("fips128_latency", 512'(lat), 512'(1538));
        chk("fips128_data_out", 512'(bus0.data_out), 512'(CT128));
        @(negedge clk);
        chk("fips128_sclk_rises", 512'(last_rises[0]), 512'(384));
        chk("fips128_mosi_key_pt", 512'(last_stream[0][511:256]), 512'({PT, K128}));
        chk("fips128_mosi_tail_zero", 512'(last_stream[0][255:128]), 512'(0));

        // FIPS-197 AES-256 through the Nk=8, CLK_DIV=1 instance
        run_txn(1, PT, K256, lat);
        chk("fips256_latency", 512'(lat), 512'(1025));
        chk("fips256_data_out", 512'(bus1.data_out), 512'(CT256));
        @(negedge clk);
        chk("fips256_sclk_rises", 512'(last_rises[1]), 512'(512));
        chk("fips256_mosi_key_pt", 512'(last_stream[1][511:128]), 512'({PT, K256}));

        // Extra start pulses with different data while busy are ignored
        pulse_start(0, PT, {K128, 128'b0});
        repeat (9) @(negedge clk);
        drive(0, 1'b1, rand128(), {rand128(), rand128()});
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (989) @(negedge clk);
        drive(0, 1'b1, rand128(), {rand128(), rand128()});
        @(negedge clk);
        set_start(0, 1'b0);
        wait_done(0, 600, lat);
        chk("restart_latency", 512'(lat + 1000), 512'(1538));
        chk("restart_data_out", 512'(bus0.data_out), 512'(CT128));
        @(negedge clk);
        chk("restart_sclk_rises", 512'(last_rises[0]), 512'(384));

        // Reset at cycle 700 aborts, then a fresh transaction completes
        pulse_start(0, PT, {K128, 128'b0});
        repeat (699) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 512'(act_vec(0)), 512'({128'b0, 5'b10000}));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_txn(0, PT, {K128, 128'b0}, lat);
        chk("after_abort_latency", 512'(lat), 512'(1538));
        chk("after_abort_data_out", 512'(bus0.data_out), 512'(CT128));

        // start during FINISH is ignored, one cycle later it is taken
        pt = rand128();
        k = {rand128(), rand128()};
        drive(0, 1'b1, pt, k);
        @(negedge clk);
        chk("finish_start_ignored", 512'({cs0, bus0.busy}), 512'(2'b10));
        @(negedge clk);
        set_start(0, 1'b0);
        chk("idle_start_taken", 512'({cs0, bus0.busy}), 512'(2'b01));
        wait_done(0, busy_len(0) + 20, lat);
        chk("idle_start_latency", 512'(lat), 512'(1538));
        chk("idle_start_data_out", 512'(bus0.data_out), 512'(oracle(stream_of(0, pt, k), 256)));

        // Randomised transactions on both instances
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 2;
            pt = rand128();
            k = {rand128(), rand128()};
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_txn(g, pt, k, lat);
            chk($sformatf("rand%0d_latency", i), 512'(lat), 512'(busy_len(g)));
            chk($sformatf("rand%0d_data_out", i), 512'(g == 0 ? bus0.data_out : bus1.data_out),
                512'(oracle(stream_of(g, pt, k), txw_of(g))));
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_aes.md
SPI_MASTER_AES -- requirements
Module: spi_master_aes

Interface
REQ-001 Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 CLK_DIV, 2, system clocks per SCLK half-period; legal range 1..255.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle request to run one encryption transaction.
REQ-006 data_in  in  128  plaintext block.
REQ-007 key_in  in  32*Nk  cipher key.
REQ-008 data_out  out  128  ciphertext from the last completed transaction.
REQ-009 busy  out  1  high while a transaction is in progress.
REQ-010 done  out  1  one-cycle pulse on transaction completion.
REQ-011 SCLK  out  1  serial clock to the AES SPI slave; idle low.
REQ-012 MOSI  out  1  serial data to the slave's SDI.
REQ-013 MISO  in  1  serial data from the slave's SDO.
REQ-014 CS  out  1  active-low chip select to the slave; idle high.

Function
REQ-015 FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, FINISH; reset state IDLE.
REQ-016 IDLE: start=1 latches data_in and key_in into an internal TX shift register of 128+32*Nk bits (plaintext MSBs first, then key) and moves to SETUP; start is ignored in every other state.
REQ-017 SETUP entry: CS=0, busy=1, SCLK=0, MOSI=plaintext bit 127; SETUP lasts CLK_DIV cycles, then SHIFT_HI.
REQ-018 Transaction length: N = 256+32*Nk SCLK periods (384/448/512 for Nk 4/6/8); a 9-bit+ bit counter tracks the periods.
REQ-019 SHIFT_HI: SCLK=1 for CLK_DIV cycles; on entry in periods 0..(127+32*Nk), MOSI holds and is not changed.
REQ-020 SHIFT_HI, receive periods (index >= 128+32*Nk): MISO sampled on the last clk of the high phase and shifted into the RX register LSB-side (MSB received first).
REQ-021 SHIFT_LO: SCLK=0 for CLK_DIV cycles; on entry, MOSI updates to the next TX bit; once all TX bits are sent, MOSI=0.
REQ-022 After SHIFT_LO of period N-1: FINISH, lasting one cycle, with CS=1, SCLK=0, MOSI=0, busy=0, done=1, data_out loaded from the RX register; then IDLE.
REQ-023 busy is high for exactly CLK_DIV*(1+2*N) cycles per transaction.
REQ-024 start asserted during the FINISH cycle is ignored; start is accepted on the following cycle (IDLE).
REQ-025 data_out changes only in FINISH; it holds its value between transactions and is unaffected by input changes during busy.
REQ-026 The half-period counter reloads at every phase change; CLK_DIV=1 gives SCLK = clk/2.

Reset
REQ-027 rst=1 forces within one clk: state IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, data_out=0, all counters and shift registers 0.
REQ-028 rst asserted mid-transaction aborts it with no done pulse; CS rises on the same edge so the slave discards partial data.
REQ-029 rst has priority over start on the same edge.

Verification
REQ-030 Nk=4, CLK_DIV=2, data_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f, slave model returns FIPS-197 result -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a, done pulse exactly 1538 cycles after the start cycle.
REQ-031 Same stimulus: MOSI bitstream captured on SCLK rising edges -> 256 bits equal to data_in followed by key_in, MSB first; next 128 bits are 0; 384 rising SCLK edges counted.
REQ-032 Nk=8, CLK_DIV=1, key 000102...1f, plaintext as above -> data_out=8ea2b7ca516745bfeafc49904b496089, 512 SCLK periods.
REQ-033 start pulsed again at cycles 10 and 1000 of a running transaction -> ignored: single done pulse, SCLK count unchanged.
REQ-034 rst asserted at cycle 700 of a transaction -> CS=1, SCLK=0, busy=0, data_out=0 on the next edge, no done pulse; a new start then completes normally.
REQ-035 start on the FINISH cycle is ignored; start one cycle later begins a new transaction with CS low on the next edge.
